// File: rtl/pipe_isa_pkg.sv
// Shared ISA definitions for the issue front-end: instruction field layout,
// the no-op function code and the ALU function codes.
package pipe_isa_pkg;

  localparam int REG_W   = 4;
  localparam int FUNC_W  = 4;
  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 24;

  localparam int RS1_LSB  = 20;
  localparam int RS2_LSB  = 16;
  localparam int RD_LSB   = 12;
  localparam int FUNC_LSB = 8;
  localparam int ADDR_LSB = 0;

  localparam logic [FUNC_W-1:0] NOP_FUNC_DEF = 4'hF;

  localparam logic [FUNC_W-1:0] FUNC_ADD = 4'h0;
  localparam logic [FUNC_W-1:0] FUNC_SUB = 4'h1;
  localparam logic [FUNC_W-1:0] FUNC_AND = 4'h2;
  localparam logic [FUNC_W-1:0] FUNC_OR  = 4'h3;
  localparam logic [FUNC_W-1:0] FUNC_XOR = 4'h4;
  localparam logic [FUNC_W-1:0] FUNC_LD  = 4'h8;
  localparam logic [FUNC_W-1:0] FUNC_ST  = 4'h9;

  typedef struct packed {
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [REG_W-1:0]  rd;
    logic [FUNC_W-1:0] func;
    logic [ADDR_W-1:0] addr;
  } instr_t;

  function automatic instr_t unpack_instr(input logic [INSTR_W-1:0] w);
    instr_t i;
    i.rs1  = w[RS1_LSB  +: REG_W];
    i.rs2  = w[RS2_LSB  +: REG_W];
    i.rd   = w[RD_LSB   +: REG_W];
    i.func = w[FUNC_LSB +: FUNC_W];
    i.addr = w[ADDR_LSB +: ADDR_W];
    return i;
  endfunction

endpackage

// File: rtl/pipe_issue_unit_if.sv
// Host write port plus pipeline-facing issue outputs of pipe_issue_unit.
// master = host/pipeline side, slave = the issue unit itself.
interface pipe_issue_unit_if #(parameter int DEPTH = 8);
  import pipe_isa_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic               wr_en;
  logic [INSTR_W-1:0] wr_instr;
  logic               issue_en;
  logic               full;
  logic               empty;
  logic [CNT_W-1:0]   count;
  logic               ovf;
  logic [REG_W-1:0]   rs1;
  logic [REG_W-1:0]   rs2;
  logic [REG_W-1:0]   rd;
  logic [FUNC_W-1:0]  func;
  logic [ADDR_W-1:0]  addr;
  logic               issue_valid;
  logic               stall;
  logic [15:0]        issued_cnt;

  modport master (
    output wr_en, wr_instr, issue_en,
    input  full, empty, count, ovf, rs1, rs2, rd, func, addr,
           issue_valid, stall, issued_cnt
  );

  modport slave (
    input  wr_en, wr_instr, issue_en,
    output full, empty, count, ovf, rs1, rs2, rd, func, addr,
           issue_valid, stall, issued_cnt
  );

endinterface

// File: rtl/pipe_issue_fifo.sv
// Instruction FIFO: storage, wrapping pointers, occupancy count and the
// sticky overflow flag. Writes while full are dropped and never credited by a pop.
module pipe_issue_fifo
  import pipe_isa_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en_i,
  input  logic [INSTR_W-1:0]         wr_data_i,
  input  logic                       pop_i,
  output logic [INSTR_W-1:0]         head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       ovf_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [INSTR_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   count_d;
  logic               ovf_q;
  logic               ovf_d;
  logic               push_s;
  logic               pop_s;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == {CNT_W{1'b0}});
  assign count_o = count_q;
  assign ovf_o   = ovf_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Accepted push/pop and the resulting occupancy and overflow state
  always_comb begin
    push_s  = wr_en_i && !full_o;
    pop_s   = pop_i && !empty_o;
    ovf_d   = ovf_q | (wr_en_i & full_o);
    count_d = count_q;
    if (push_s && !pop_s) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop_s && !push_s) begin
      count_d = count_q - CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Storage, pointers and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {INSTR_W{1'b0}};
      end
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
      ovf_q    <= 1'b0;
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q] <= wr_data_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: rtl/pipe_issue_unit.sv
// Issue front-end: FIFO-buffered instructions issued one per cycle into registered
// operand outputs. Define HAZARD_CHECK_EN to enable RAW bubble insertion.
module pipe_issue_unit
  import pipe_isa_pkg::*;
#(
  parameter int                DEPTH      = 8,
  parameter int                HAZARD_WIN = 2,
  parameter logic [FUNC_W-1:0] NOP_FUNC   = NOP_FUNC_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  pipe_issue_unit_if.slave bus
);

  if (HAZARD_WIN < 1 || HAZARD_WIN > 4 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_cfg_bad
    $error("pipe_issue_unit: unsupported DEPTH or HAZARD_WIN");
  end

  logic [INSTR_W-1:0] head_raw_s;
  instr_t             head_s;
  logic               fifo_empty_s;
  logic               hazard_s;
  logic               fire_s;
  logic               stall_d;

  logic [REG_W-1:0]   rs1_q;
  logic [REG_W-1:0]   rs2_q;
  logic [REG_W-1:0]   rd_q;
  logic [FUNC_W-1:0]  func_q;
  logic [ADDR_W-1:0]  addr_q;
  logic               valid_q;
  logic               stall_q;
  logic [15:0]        issued_cnt_q;

  pipe_issue_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (bus.wr_en),
    .wr_data_i (bus.wr_instr),
    .pop_i     (fire_s),
    .head_o    (head_raw_s),
    .full_o    (bus.full),
    .empty_o   (fifo_empty_s),
    .count_o   (bus.count),
    .ovf_o     (bus.ovf)
  );

  assign head_s = unpack_instr(head_raw_s);

`ifdef HAZARD_CHECK_EN
  logic [HAZARD_WIN-1:0] sb_v_q;
  logic [REG_W-1:0]      sb_rd_q [HAZARD_WIN];

  // RAW check of the head's sources against recently issued destinations
  always_comb begin
    hazard_s = 1'b0;
    for (int i = 0; i < HAZARD_WIN; i++) begin
      if (sb_v_q[i] && ((sb_rd_q[i] == head_s.rs1) || (sb_rd_q[i] == head_s.rs2))) begin
        hazard_s = 1'b1;
      end else begin
        hazard_s = hazard_s;
      end
    end
  end

  // Scoreboard shift: bubbles enter as invalid so hazards age out on their own
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_v_q <= {HAZARD_WIN{1'b0}};
      for (int i = 0; i < HAZARD_WIN; i++) begin
        sb_rd_q[i] <= {REG_W{1'b0}};
      end
    end else begin
      sb_v_q[0]  <= fire_s;
      sb_rd_q[0] <= head_s.rd;
      for (int i = 1; i < HAZARD_WIN; i++) begin
        sb_v_q[i]  <= sb_v_q[i-1];
        sb_rd_q[i] <= sb_rd_q[i-1];
      end
    end
  end
`else
  assign hazard_s = 1'b0;
`endif

  // Issue decision for the current head
  always_comb begin
    fire_s  = bus.issue_en && !fifo_empty_s && !hazard_s;
    stall_d = bus.issue_en && !fifo_empty_s && hazard_s;
  end

  // Issue register and counter; non-issue cycles drive a no-op and hold operands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs1_q        <= {REG_W{1'b0}};
      rs2_q        <= {REG_W{1'b0}};
      rd_q         <= {REG_W{1'b0}};
      func_q       <= NOP_FUNC;
      addr_q       <= {ADDR_W{1'b0}};
      valid_q      <= 1'b0;
      stall_q      <= 1'b0;
      issued_cnt_q <= 16'h0000;
    end else begin
      stall_q <= stall_d;
      if (fire_s) begin
        rs1_q        <= head_s.rs1;
        rs2_q        <= head_s.rs2;
        rd_q         <= head_s.rd;
        func_q       <= head_s.func;
        addr_q       <= head_s.addr;
        valid_q      <= 1'b1;
        issued_cnt_q <= issued_cnt_q + 16'h0001;
      end else begin
        func_q  <= NOP_FUNC;
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.empty       = fifo_empty_s;
  assign bus.rs1         = rs1_q;
  assign bus.rs2         = rs2_q;
  assign bus.rd          = rd_q;
  assign bus.func        = func_q;
  assign bus.addr        = addr_q;
  assign bus.issue_valid = valid_q;
  assign bus.stall       = stall_q;
  assign bus.issued_cnt  = issued_cnt_q;

endmodule
